// File: rtl/sar_pkg.sv
// Shared definitions for the SAR sequencer: state/phase encodings and defaults.
package sar_pkg;

  localparam int DEF_N             = 8;
  localparam int DEF_SAMPLE_CYCLES = 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SAMPLE = 2'd1,
    ST_CONV   = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  // Each bit takes two cycles: drive the trial code, then latch the decision.
  typedef enum logic {
    PH_TRIAL = 1'b0,
    PH_LATCH = 1'b1
  } phase_t;

endpackage

// File: rtl/sar_ctrl_if.sv
// Bundle between the request/analog side and the SAR sequencer.
//
// Handshake: there is no ready/backpressure. `start` is a level request that
// is only accepted while the sequencer is in IDLE or DONE; `abort` cancels any
// conversion and wins over `start`. `valid` is a single-cycle pulse that marks
// the cycle in which `data_out` carries a fresh result; the consumer must take
// it in that cycle (data_out stays held afterwards until the next result).
interface sar_ctrl_if #(
  parameter int N = sar_pkg::DEF_N
);
  logic         start;
  logic         abort;
  logic         cmp_out;
  logic         sample;
  logic         div_en;
  logic [N-1:0] dac_code;
  logic         busy;
  logic [N-1:0] data_out;
  logic         valid;

  // Request logic and comparator side.
  modport master (
    output start, abort, cmp_out,
    input  sample, div_en, dac_code, busy, data_out, valid
  );

  // Sequencer side.
  modport slave (
    input  start, abort, cmp_out,
    output sample, div_en, dac_code, busy, data_out, valid
  );
endinterface

// File: rtl/sar_reg.sv
// N-bit successive-approximation register with trial-code view.
module sar_reg #(
  parameter int N = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic [$clog2(N)-1:0] idx,
  input  logic                 set_bit,
  input  logic                 d,
  output logic [N-1:0]         sar,
  output logic [N-1:0]         trial
);

  logic [N-1:0] r_sar;
  logic [N-1:0] w_mask;

  assign w_mask = N'(1) << idx;

  // Clear at conversion start; otherwise write the decided bit at idx.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_sar <= '0;
    end else if (set_bit) begin
      r_sar <= d ? (r_sar | w_mask) : (r_sar & ~w_mask);
    end
  end

  assign sar   = r_sar;
  assign trial = r_sar | w_mask;

endmodule

// File: rtl/sar_ctrl.sv
// Successive-approximation sequencer: track phase, N bit trials MSB..LSB,
// then a one-cycle result pulse. All outputs are registered.
module sar_ctrl
  import sar_pkg::*;
#(
  parameter int N             = DEF_N,
  parameter int SAMPLE_CYCLES = DEF_SAMPLE_CYCLES
) (
  input  logic           clk,
  input  logic           rst,
  sar_ctrl_if.slave      bus,
  output state_t         o_state
);

  localparam int IW = $clog2(N);
  localparam int CW = $clog2(SAMPLE_CYCLES + 1);

  state_t          r_state;
  phase_t          r_phase;
  logic [IW-1:0]   r_idx;
  logic [CW-1:0]   r_cnt;
  logic            r_sample;
  logic            r_div_en;
  logic            r_busy;
  logic            r_valid;
  logic [N-1:0]    r_dac;
  logic [N-1:0]    r_data;

  logic            w_go;
  logic            w_sample_end;
  logic            w_clr;
  logic            w_set_bit;
  logic [N-1:0]    w_sar;
  logic [N-1:0]    w_trial;
  logic [N-1:0]    w_mask;
  logic [N-1:0]    w_latched;
  logic [N-1:0]    w_next_trial;

  assign w_go         = bus.start && !bus.abort;
  assign w_sample_end = (r_cnt == CW'(SAMPLE_CYCLES - 1));
  assign w_clr        = (r_state == ST_SAMPLE) && w_sample_end;
  assign w_set_bit    = (r_state == ST_CONV) && (r_phase == PH_LATCH);
  assign w_mask       = N'(1) << r_idx;
  // sar[idx] is still 0 here, so keeping the bit means taking the trial code.
  assign w_latched    = bus.cmp_out ? w_trial : w_sar;
  assign w_next_trial = w_latched | (w_mask >> 1);

  sar_reg #(.N(N)) u_sar_reg (
    .clk     (clk),
    .rst     (rst),
    .clr     (w_clr),
    .idx     (r_idx),
    .set_bit (w_set_bit),
    .d       (bus.cmp_out),
    .sar     (w_sar),
    .trial   (w_trial)
  );

  // Sequencer FSM with its counters and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_phase  <= PH_TRIAL;
      r_idx    <= '0;
      r_cnt    <= '0;
      r_sample <= 1'b0;
      r_div_en <= 1'b0;
      r_busy   <= 1'b0;
      r_valid  <= 1'b0;
      r_dac    <= '0;
      r_data   <= '0;
    end else begin
      r_valid <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (w_go) begin
            r_state  <= ST_SAMPLE;
            r_cnt    <= '0;
            r_dac    <= '0;
            r_sample <= 1'b1;
            r_busy   <= 1'b1;
          end
        end
        ST_SAMPLE: begin
          if (bus.abort) begin
            r_state  <= ST_IDLE;
            r_sample <= 1'b0;
            r_busy   <= 1'b0;
            r_dac    <= '0;
          end else if (w_sample_end) begin
            r_state  <= ST_CONV;
            r_idx    <= IW'(N - 1);
            r_phase  <= PH_TRIAL;
            r_dac    <= {1'b1, {(N-1){1'b0}}};
            r_sample <= 1'b0;
            r_div_en <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_CONV: begin
          if (bus.abort) begin
            r_state  <= ST_IDLE;
            r_div_en <= 1'b0;
            r_busy   <= 1'b0;
            r_dac    <= '0;
          end else if (r_phase == PH_TRIAL) begin
            r_phase <= PH_LATCH;
          end else if (r_idx == '0) begin
            r_state  <= ST_DONE;
            r_div_en <= 1'b0;
            r_data   <= w_latched;
            r_valid  <= 1'b1;
          end else begin
            r_idx   <= r_idx - 1'b1;
            r_phase <= PH_TRIAL;
            r_dac   <= w_next_trial;
          end
        end
        ST_DONE: begin
          if (w_go) begin
            r_state  <= ST_SAMPLE;
            r_cnt    <= '0;
            r_dac    <= '0;
            r_sample <= 1'b1;
          end else if (bus.abort) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_dac   <= '0;
          end else begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.sample   = r_sample;
  assign bus.div_en   = r_div_en;
  assign bus.dac_code = r_dac;
  assign bus.busy     = r_busy;
  assign bus.data_out = r_data;
  assign bus.valid    = r_valid;
  assign o_state      = r_state;

endmodule

// File: doc/sar_ctrl.md
# sar_ctrl

Successive-approximation sequencer for the time-domain SAR ADC. It runs one conversion per accepted `start`: track phase, then N bit trials from MSB to LSB, then a one-cycle result pulse. It drives the trial code to the DAC/time-reference and the enable of the comparator clock divider, and it captures the comparator decision once per bit. It sits between the system-side request logic and the analog front end, on the main clock.

## Interface
- `N`, 8: resolution in bits; legal range N ≥ 2.
- `SAMPLE_CYCLES`, 2: length of the track phase in clk cycles; legal range ≥ 1.

Ports:
- `clk` input 1: system clock; all logic on posedge.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: conversion request, level-sampled; accepted in IDLE or DONE.
- `abort` input 1: cancels the conversion in progress; takes priority over `start`.
- `cmp_out` input 1: comparator decision. 1 means input ≥ trial, so the bit is kept.
- `sample` output 1: track/hold control; high during the SAMPLE state.
- `div_en` output 1: enable for the comparator clock divider; high during CONV.
- `dac_code` output N: current trial code.
- `busy` output 1: high in SAMPLE, CONV and DONE.
- `data_out` output N: last completed result; held until the next completed conversion.
- `valid` output 1: one-cycle pulse when `data_out` is updated.

## Operation
- States: IDLE, SAMPLE, CONV, DONE. Each state has a phase flag: TRIAL=0, LATCH=1.
- IDLE:
  - `start`=1 and `abort`=0 → SAMPLE, sample counter cleared, `dac_code`←0.
  - Otherwise stay in IDLE.
- SAMPLE:
  - `sample`=1 for exactly SAMPLE_CYCLES cycles.
  - Then → CONV, with bit index = N-1, phase = TRIAL, and the working register `sar`←0.
- CONV, TRIAL cycle:
  - `dac_code` = `sar` | (1 << idx).
  - `div_en`=1.
  - Next phase is LATCH.
- CONV, LATCH cycle:
  - `dac_code` is unchanged.
  - `sar[idx]`←`cmp_out`.
  - If idx=0 → DONE; otherwise idx←idx-1 and phase←TRIAL.
- DONE (one cycle):
  - `data_out`←`sar`, `valid`=1.
  - If `start`=1 and `abort`=0 → SAMPLE (back-to-back conversion); otherwise → IDLE.
- `abort`=1 in SAMPLE, CONV or DONE:
  - Next state is IDLE.
  - `data_out` is not updated and no `valid` pulse is produced.
  - `dac_code`←0.
  - If `abort` arrives in DONE, that same cycle's `valid` and `data_out` update still happen, because the register is written on the entering edge.
- `start` in SAMPLE or CONV is ignored; nothing is queued.
- Widths:
  - idx: $clog2(N) bits.
  - Sample counter: $clog2(SAMPLE_CYCLES+1) bits.
  - No arithmetic overflow is possible. The result lies in 0..2^N-1.

## Timing
- Reset values: state=IDLE, `sample`=0, `div_en`=0, `dac_code`=0, `busy`=0, `data_out`=0, `valid`=0.
- `rst` asserted mid-conversion returns to IDLE on the next edge, with no `valid` pulse.
- All outputs are registered; nothing combinational runs from inputs to outputs.
- Latency:
  - `start` sampled at edge k.
  - SAMPLE occupies cycles k+1..k+SAMPLE_CYCLES.
  - CONV occupies 2N cycles.
  - `valid` is high in cycle k+SAMPLE_CYCLES+2N+1.
  - For N=8, SAMPLE_CYCLES=2: `valid` 19 cycles after `start`.
- `cmp_out` must be stable at the edge that ends the LATCH cycle. The comparator therefore has one full TRIAL cycle of settling.
- Throughput with back-to-back `start`: one result per SAMPLE_CYCLES+2N+1 cycles.
- `div_en` falls on the edge entering DONE or IDLE. The divider's own reset-on-`!en` behaviour restarts its phase on every conversion.

## Structure
- Shared package `sar_pkg` holds:
  - The state encoding constants (IDLE, SAMPLE, CONV, DONE).
  - The phase constants (TRIAL, LATCH).
  - The default resolution.
- One sub-module, `sar_reg`: the N-bit approximation register. It has `clr`, `idx`, `set_bit`, `d` inputs and exposes `sar` and `trial` = `sar` | (1<<`idx`).
- The FSM, the counters and the output registers stay in `sar_ctrl`.

## Test plan
All scenarios use N=8 and SAMPLE_CYCLES=2 unless stated otherwise.
- Comparator model with input=0x5A, `cmp_out`=(0x5A ≥ `dac_code`) → `dac_code` sequence 0x80, 0x40, 0x60, 0x50, 0x58, 0x5C, 0x5A, 0x5B; `data_out`=0x5A with `valid` at cycle 19.
- `cmp_out` tied to 1 → `data_out`=0xFF. `cmp_out` tied to 0 → `data_out`=0x00. Each result has exactly one `valid` pulse.
- `abort` pulsed during the 3rd bit trial → IDLE next cycle, `dac_code`=0, `data_out` keeps its previous value, no `valid`.
- `rst` asserted mid-CONV → all outputs at their reset values the next cycle, including `data_out`=0.
- `start` held high continuously → results every 19 cycles. Extra `start` pulses during CONV produce no additional conversions.
- `start` and `abort` high together in IDLE → stays in IDLE, `busy`=0.
